// File: rtl/conv_core_param_if.sv
// rtl/conv_core_param_if.sv - memory-side bus of the convolution engine (X/Y read ports, Z write port)
interface conv_core_param_if #(
    parameter int DATA_WIDTH_X = 8,
    parameter int DATA_WIDTH_Y = 8,
    parameter int DATA_WIDTH_Z = 16,
    parameter int ADDR_WIDTH_X = 5,
    parameter int ADDR_WIDTH_Y = 5,
    parameter int ADDR_WIDTH_Z = 6
);
    logic [ADDR_WIDTH_X-1:0] memX_addr;
    logic [DATA_WIDTH_X-1:0] dataX;
    logic [ADDR_WIDTH_Y-1:0] memY_addr;
    logic [DATA_WIDTH_Y-1:0] dataY;
    logic [ADDR_WIDTH_Z-1:0] memZ_addr;
    logic [DATA_WIDTH_Z-1:0] dataZ;
    logic                    writeZ;

    // Engine side: drives addresses and Z write, receives synchronous-read data.
    modport master (
        output memX_addr,
        input  dataX,
        output memY_addr,
        input  dataY,
        output memZ_addr,
        output dataZ,
        output writeZ
    );

    // Memory side.
    modport slave (
        input  memX_addr,
        output dataX,
        input  memY_addr,
        output dataY,
        input  memZ_addr,
        input  dataZ,
        input  writeZ
    );
endinterface

// File: rtl/conv_core_param.sv
// rtl/conv_core_param.sv - parametrised linear convolution engine Z = X * Y over memory operands
module conv_core_param #(
    parameter int DATA_WIDTH_X = 8,
    parameter int DATA_WIDTH_Y = 8,
    parameter int DATA_WIDTH_Z = 16,
    parameter int ADDR_WIDTH_X = 5,
    parameter int ADDR_WIDTH_Y = 5,
    parameter int ADDR_WIDTH_Z = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [ADDR_WIDTH_X:0]   sizeX,
    input  logic [ADDR_WIDTH_Y:0]   sizeY,
    input  logic                    signed_mode,
    input  logic                    sat_en,
    conv_core_param_if.master       mem_if,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf
);
    localparam int DX     = DATA_WIDTH_X;
    localparam int DY     = DATA_WIDTH_Y;
    localparam int DZ     = DATA_WIDTH_Z;
    localparam int AX     = ADDR_WIDTH_X;
    localparam int AY     = ADDR_WIDTH_Y;
    localparam int AZ     = ADDR_WIDTH_Z;
    localparam int AW_MIN = (AX < AY) ? AX : AY;
    // Wide enough that min(Sx,Sy) full-scale products can never wrap.
    localparam int ACC_W  = DX + DY + AW_MIN + 1;
    // Output index / size arithmetic width; holds Sx+Sy without wrapping.
    localparam int WN     = AZ + 1;

    localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-DZ+1){1'b0}}, {(DZ-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-DZ+1){1'b1}}, {(DZ-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] U_MAX = {{(ACC_W-DZ){1'b0}}, {DZ{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ISSUE,
        S_DRAIN,
        S_WRITE
    } state_t;

    state_t                   state_q, state_d;
    logic [AX:0]              sx_q, sx_d;
    logic [AY:0]              sy_q, sy_d;
    logic                     sgn_q, sgn_d;
    logic                     sat_q, sat_d;
    logic [WN-1:0]            nz_q, nz_d;
    logic [WN-1:0]            n_q, n_d;
    logic                     first_q, first_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [AX-1:0]            addr_x_q, addr_x_d;
    logic [AY-1:0]            addr_y_q, addr_y_d;
    logic [AZ-1:0]            addr_z_q, addr_z_d;
    logic [DZ-1:0]            data_z_q, data_z_d;
    logic                     write_z_q, write_z_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;

    logic [AX:0]              size_x_clamped;
    logic [AY:0]              size_y_clamped;
    logic [WN-1:0]            sx_w, sy_w, n_inc, kmin_nx, kmax_cur, kx_w;
    logic [AY-1:0]            ky_nx;

    logic signed [DX:0]       x_ext;
    logic signed [DY:0]       y_ext;
    logic signed [ACC_W-1:0]  x_wide, y_wide, prod, sum, z_hi, z_lo;
    logic                     too_hi, too_lo;
    logic [DZ-1:0]            z_conv;

    assign mem_if.memX_addr = addr_x_q;
    assign mem_if.memY_addr = addr_y_q;
    assign mem_if.memZ_addr = addr_z_q;
    assign mem_if.dataZ     = data_z_q;
    assign mem_if.writeZ    = write_z_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign ovf              = ovf_q;

    // Size clamp and k-range bookkeeping for the current and the next output index.
    always_comb begin
        size_x_clamped = (sizeX[AX] && (|sizeX[AX-1:0])) ? {1'b1, {AX{1'b0}}} : sizeX;
        size_y_clamped = (sizeY[AY] && (|sizeY[AY-1:0])) ? {1'b1, {AY{1'b0}}} : sizeY;
        sx_w     = WN'(sx_q);
        sy_w     = WN'(sy_q);
        n_inc    = n_q + WN'(1);
        kmin_nx  = (n_inc >= sy_w) ? (n_inc - sy_w + WN'(1)) : '0;
        ky_nx    = AY'(n_inc - kmin_nx);
        kmax_cur = (n_q < (sx_w - WN'(1))) ? n_q : (sx_w - WN'(1));
        kx_w     = WN'(addr_x_q);
    end

    // Product of the operands read last cycle, running sum, and conversion to the Z range.
    always_comb begin
        x_ext  = {sgn_q & mem_if.dataX[DX-1], mem_if.dataX};
        y_ext  = {sgn_q & mem_if.dataY[DY-1], mem_if.dataY};
        x_wide = {{(ACC_W-DX-1){x_ext[DX]}}, x_ext};
        y_wide = {{(ACC_W-DY-1){y_ext[DY]}}, y_ext};
        prod   = x_wide * y_wide;
        sum    = acc_q + prod;
        z_hi   = sgn_q ? S_MAX : U_MAX;
        z_lo   = sgn_q ? S_MIN : '0;
        too_hi = (sum > z_hi);
        too_lo = (sum < z_lo);
        z_conv = sum[DZ-1:0];
        if (sat_q) begin
            if (too_hi) begin
                z_conv = z_hi[DZ-1:0];
            end else if (too_lo) begin
                z_conv = z_lo[DZ-1:0];
            end
        end
    end

    // Next-state and next-output logic of the run sequencer.
    always_comb begin
        state_d   = state_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        sgn_d     = sgn_q;
        sat_d     = sat_q;
        nz_d      = nz_q;
        n_d       = n_q;
        first_d   = first_q;
        acc_d     = acc_q;
        addr_x_d  = addr_x_q;
        addr_y_d  = addr_y_q;
        addr_z_d  = addr_z_q;
        data_z_d  = data_z_q;
        write_z_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    sx_d    = size_x_clamped;
                    sy_d    = size_y_clamped;
                    sgn_d   = signed_mode;
                    sat_d   = sat_en;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                n_d  = '0;
                nz_d = sx_w + sy_w - WN'(1);
                if ((sx_q == '0) || (sy_q == '0)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_x_d = '0;
                    addr_y_d = '0;
                    first_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Read data in the first issue cycle of an output belongs to no term of it.
                acc_d   = first_q ? '0 : sum;
                first_d = 1'b0;
                if (kx_w == kmax_cur) begin
                    state_d = S_DRAIN;
                end else begin
                    addr_x_d = addr_x_q + AX'(1);
                    addr_y_d = addr_y_q - AY'(1);
                end
            end
            S_DRAIN: begin
                acc_d     = sum;
                write_z_d = 1'b1;
                addr_z_d  = AZ'(n_q);
                data_z_d  = z_conv;
                if (too_hi || too_lo) begin
                    ovf_d = 1'b1;
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (n_inc < nz_q) begin
                    n_d      = n_inc;
                    addr_x_d = AX'(kmin_nx);
                    addr_y_d = ky_nx;
                    first_d  = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and all registered outputs; reset aborts a run at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            sx_q      <= '0;
            sy_q      <= '0;
            sgn_q     <= 1'b0;
            sat_q     <= 1'b0;
            nz_q      <= '0;
            n_q       <= '0;
            first_q   <= 1'b0;
            acc_q     <= '0;
            addr_x_q  <= '0;
            addr_y_q  <= '0;
            addr_z_q  <= '0;
            data_z_q  <= '0;
            write_z_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            sgn_q     <= sgn_d;
            sat_q     <= sat_d;
            nz_q      <= nz_d;
            n_q       <= n_d;
            first_q   <= first_d;
            acc_q     <= acc_d;
            addr_x_q  <= addr_x_d;
            addr_y_q  <= addr_y_d;
            addr_z_q  <= addr_z_d;
            data_z_q  <= data_z_d;
            write_z_q <= write_z_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule

// File: tb/tb_conv_core_param.sv
// tb/tb_conv_core_param.sv - scoreboard bench for conv_core_param against a direct convolution model
module tb_conv_core_param;
    localparam int DX = 8;
    localparam int DY = 8;
    localparam int DZ = 16;
    localparam int AX = 5;
    localparam int AY = 5;
    localparam int AZ = 6;
    localparam int DEPTH = 32;

    typedef struct {
        int             addr;
        logic [DZ-1:0]  data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AX:0]   sizeX = '0;
    logic [AY:0]   sizeY = '0;
    logic          signed_mode = 1'b0;
    logic          sat_en = 1'b0;
    logic          busy, done, ovf;

    logic [DX-1:0] memx [DEPTH];
    logic [DY-1:0] memy [DEPTH];

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic prev_w = 1'b0;

    conv_core_param_if #(
        .DATA_WIDTH_X(DX), .DATA_WIDTH_Y(DY), .DATA_WIDTH_Z(DZ),
        .ADDR_WIDTH_X(AX), .ADDR_WIDTH_Y(AY), .ADDR_WIDTH_Z(AZ)
    ) mem_if ();

    conv_core_param #(
        .DATA_WIDTH_X(DX), .DATA_WIDTH_Y(DY), .DATA_WIDTH_Z(DZ),
        .ADDR_WIDTH_X(AX), .ADDR_WIDTH_Y(AY), .ADDR_WIDTH_Z(AZ)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .sizeX(sizeX),
        .sizeY(sizeY),
        .signed_mode(signed_mode),
        .sat_en(sat_en),
        .mem_if(mem_if.master),
        .busy(busy),
        .done(done),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Synchronous-read X/Y memories.
    always @(posedge clk) begin
        mem_if.dataX <= memx[mem_if.memX_addr];
        mem_if.dataY <= memy[mem_if.memY_addr];
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sval(input logic [7:0] v, input bit sgn);
        if (sgn) return longint'($signed(v));
        return longint'(v);
    endfunction

    // Direct convolution sum per output, then range conversion; pushes up to n_lim results.
    task automatic model_push(input int sx, input int sy, input bit sgn, input bit sat,
                              input int n_lim, output bit eovf);
        longint lo, hi;
        eovf = 1'b0;
        lo = sgn ? -(longint'(1) <<< (DZ-1)) : 0;
        hi = sgn ? (longint'(1) <<< (DZ-1)) - 1 : (longint'(1) <<< DZ) - 1;
        if (sx == 0 || sy == 0) return;
        for (int n = 0; n < sx + sy - 1 && n < n_lim; n++) begin
            longint s;
            longint v;
            exp_t   e;
            s = 0;
            for (int k = 0; k < sx; k++) begin
                if (n - k >= 0 && n - k < sy) s += sval(memx[k], sgn) * sval(memy[n-k], sgn);
            end
            v = s;
            if (s > hi || s < lo) eovf = 1'b1;
            if (sat && s > hi) v = hi;
            if (sat && s < lo) v = lo;
            e.addr = n;
            e.data = DZ'(v);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every Z write is popped against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_if.writeZ) begin
                check("writeZ_back_to_back", longint'(prev_w), 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                             mem_if.memZ_addr, mem_if.dataZ);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("z_addr", longint'(mem_if.memZ_addr), e.addr);
                    check("z_data", longint'(mem_if.dataZ), longint'(e.data));
                end
            end
            prev_w = mem_if.writeZ;
        end
    end

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            memx[i] = DX'($urandom);
            memy[i] = DY'($urandom);
        end
    endtask

    task automatic run(input int sx_in, input int sy_in, input bit sgn, input bit sat, input bit poke);
        int sx, sy, ebusy, cnt;
        bit eovf;
        sx = (sx_in > DEPTH) ? DEPTH : sx_in;
        sy = (sy_in > DEPTH) ? DEPTH : sy_in;
        model_push(sx, sy, sgn, sat, 1 << 30, eovf);
        ebusy = (sx == 0 || sy == 0) ? 1 : 1 + sx * sy + 2 * (sx + sy - 1);
        @(negedge clk);
        sizeX = (AX+1)'(sx_in);
        sizeY = (AY+1)'(sy_in);
        signed_mode = sgn;
        sat_en = sat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sizeX = (AX+1)'($urandom);
        sizeY = (AY+1)'($urandom);
        signed_mode = 1'($urandom);
        sat_en = 1'($urandom);
        cnt = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            if (poke) start = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", cnt, ebusy);
        check("done_pulse", longint'(done), 1);
        check("ovf_end", longint'(ovf), longint'(eovf));
        check("pending_writes", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("done_low", longint'(done), 0);
        check("busy_idle", longint'(busy), 0);
        check("ovf_sticky", longint'(ovf), longint'(eovf));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  cnt;
        bit  eovf;
        for (int i = 0; i < DEPTH; i++) begin
            memx[i] = '0;
            memy[i] = '0;
        end
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_writeZ", longint'(mem_if.writeZ), 0);
        check("rst_memX_addr", longint'(mem_if.memX_addr), 0);
        check("rst_memZ_addr", longint'(mem_if.memZ_addr), 0);
        check("rst_dataZ", longint'(mem_if.dataZ), 0);
        rstn = 1'b1;

        // Unsigned small case: Z = 1,3,6,6,5,3.
        memx[0] = 8'd1; memx[1] = 8'd2; memx[2] = 8'd3;
        for (int i = 0; i < 4; i++) memy[i] = 8'd1;
        run(3, 4, 1'b0, 1'b0, 1'b0);

        // Signed: X=[-1], Y=[5,-3] -> FFFB, 0003.
        memx[0] = 8'hFF; memy[0] = 8'd5; memy[1] = 8'hFD;
        run(1, 2, 1'b1, 1'b0, 1'b0);

        // Full-scale unsigned, saturating then wrapping, then a clean run clears ovf.
        memx[0] = 8'hFF; memx[1] = 8'hFF; memy[0] = 8'hFF; memy[1] = 8'hFF;
        run(2, 2, 1'b0, 1'b1, 1'b0);
        run(2, 2, 1'b0, 1'b0, 1'b0);
        memx[0] = 8'd3; memy[0] = 8'd4;
        run(1, 1, 1'b0, 1'b0, 1'b0);

        // Empty operand: no writes, one busy cycle.
        run(0, 4, 1'b0, 1'b0, 1'b0);
        run(5, 0, 1'b1, 1'b1, 1'b0);

        // Oversized sizes clamp to the memory depth.
        fill_random();
        run(40, 3, 1'b0, 1'b0, 1'b0);
        fill_random();
        run(2, 63, 1'b1, 1'b1, 1'b0);

        // Maximum sizes, signed, with start pokes during the run.
        fill_random();
        run(DEPTH, DEPTH, 1'b1, 1'($urandom), 1'b1);

        // Random sizes and modes.
        repeat (8) begin
            fill_random();
            run($urandom_range(1, DEPTH), $urandom_range(1, DEPTH), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of output n=3 of an overflowing run.
        for (int i = 0; i < DEPTH; i++) begin
            memx[i] = 8'hFF;
            memy[i] = 8'hFF;
        end
        model_push(8, 8, 1'b0, 1'b0, 3, eovf);
        @(negedge clk);
        sizeX = (AX+1)'(8); sizeY = (AY+1)'(8); signed_mode = 1'b0; sat_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!(mem_if.writeZ && mem_if.memZ_addr == AZ'(2)) && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        check("reach_n2_write", longint'(mem_if.memZ_addr), 2);
        check("ovf_before_reset", longint'(ovf), 1);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_writeZ", longint'(mem_if.writeZ), 0);
        check("abort_done", longint'(done), 0);
        check("abort_ovf", longint'(ovf), 0);
        check("abort_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_busy", longint'(busy), 0);

        // Fresh run after the abort.
        fill_random();
        run($urandom_range(1, DEPTH), $urandom_range(1, DEPTH), 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
